// File: rtl/guess_solver_pkg.sv
// Shared types, default sizes and the midpoint helper for the guess solver.
package guess_solver_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_RESP_LAT = 3;
    localparam int unsigned DEF_ATT_W    = 4;
    localparam int unsigned MID_W        = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_PRESS,
        S_WAIT,
        S_EVAL,
        S_DONE,
        S_ERROR
    } state_t;

    // Midpoint lo + ((hi-lo)>>1); operands are zero-extended WIDTH-bit
    // values, so the 32-bit arithmetic never wraps.
    function automatic logic [MID_W-1:0] mid(input logic [MID_W-1:0] lo,
                                             input logic [MID_W-1:0] hi);
        logic [MID_W-1:0] diff;
        diff = hi - lo;
        return lo + (diff >> 1);
    endfunction

endpackage

// File: rtl/guess_solver_if.sv
// Signals between the solver and the game it plays (and the start control).
interface guess_solver_if
    import guess_solver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ATT_W = DEF_ATT_W
);
    logic             i_start;
    logic             i_over;
    logic             i_under;
    logic             i_equal;
    logic [WIDTH-1:0] o_guess;
    logic             o_enter;
    logic             o_busy;
    logic             o_done;
    logic             o_error;
    logic [ATT_W-1:0] o_attempts;

    // Solver side
    modport master (
        input  i_start, i_over, i_under, i_equal,
        output o_guess, o_enter, o_busy, o_done, o_error, o_attempts
    );

    // Game / controller side
    modport slave (
        output i_start, i_over, i_under, i_equal,
        input  o_guess, o_enter, o_busy, o_done, o_error, o_attempts
    );
endinterface

// File: rtl/guess_solver_search_bounds.sv
// Binary-search window: holds lo/hi, produces the midpoint and flags
// an over/under answer that would leave the window empty.
module search_bounds
    import guess_solver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             upd_over,
    input  logic             upd_under,
    input  logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] midpoint,
    output logic             bad
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] new_lo;
    logic [WIDTH-1:0] new_hi;

    assign midpoint = WIDTH'(mid(MID_W'(lo), MID_W'(hi)));

    // Candidate window after the answer, and whether it is inconsistent
    always_comb begin
        new_lo = lo;
        new_hi = hi;
        bad    = 1'b0;
        if (upd_over) begin
            if (guess == '0) begin
                bad = 1'b1;
            end else begin
                new_hi = guess - WIDTH'(1);
                bad    = (lo > new_hi);
            end
        end else if (upd_under) begin
            if (guess == MAX) begin
                bad = 1'b1;
            end else begin
                new_lo = guess + WIDTH'(1);
                bad    = (new_lo > hi);
            end
        end
    end

    // Window register: full range on reset/start, narrowed on valid answers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo <= '0;
            hi <= MAX;
        end else if (init) begin
            lo <= '0;
            hi <= MAX;
        end else if (!bad) begin
            lo <= new_lo;
            hi <= new_hi;
        end
    end
endmodule

// File: rtl/guess_solver.sv
// Automatic binary-search player for the number-guessing game.
module guess_solver
    import guess_solver_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned RESP_LAT = DEF_RESP_LAT,
    parameter int unsigned ATT_W    = DEF_ATT_W
) (
    input  logic          clk,
    input  logic          reset,
    guess_solver_if.master bus
);
    localparam int unsigned LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    state_t           state;
    logic [WIDTH-1:0] guess;
    logic             enter;
    logic             busy;
    logic             done;
    logic             error;
    logic [ATT_W-1:0] attempts;
    logic [LAT_W-1:0] lat;

    logic [2:0]       flags;
    logic             start_ok;
    logic             upd_over;
    logic             upd_under;
    logic [WIDTH-1:0] midpoint;
    logic             bad;

    assign flags     = {bus.i_over, bus.i_under, bus.i_equal};
    assign start_ok  = bus.i_start &&
                       (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign upd_over  = (state == S_EVAL) && (flags == 3'b100);
    assign upd_under = (state == S_EVAL) && (flags == 3'b010);

    search_bounds #(.WIDTH(WIDTH)) u_bounds (
        .clk      (clk),
        .reset    (reset),
        .init     (start_ok),
        .upd_over (upd_over),
        .upd_under(upd_under),
        .guess    (guess),
        .midpoint (midpoint),
        .bad      (bad)
    );

    assign bus.o_guess    = guess;
    assign bus.o_enter    = enter;
    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_error    = error;
    assign bus.o_attempts = attempts;

    // Search sequencer with registered outputs; enter is set on the way into
    // S_PRESS so it is high for exactly the S_PRESS cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            guess    <= '0;
            enter    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            attempts <= '0;
            lat      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.i_start) begin
                        state    <= S_DRIVE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        attempts <= '0;
                    end
                end
                S_DRIVE: begin
                    guess <= midpoint;
                    enter <= 1'b1;
                    state <= S_PRESS;
                end
                S_PRESS: begin
                    enter <= 1'b0;
                    lat   <= '0;
                    if (attempts != '1) begin
                        attempts <= attempts + ATT_W'(1);
                    end
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat == LAT_W'(RESP_LAT - 1)) begin
                        state <= S_EVAL;
                    end else begin
                        lat <= lat + LAT_W'(1);
                    end
                end
                S_EVAL: begin
                    if (flags == 3'b001) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if ((upd_over || upd_under) && !bad) begin
                        state <= S_DRIVE;
                    end else begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    enter <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_guess_solver.sv
// Self-checking bench for guess_solver with a behavioural game responder.
module tb_guess_solver;
    import guess_solver_pkg::*;

    localparam int W  = 8;
    localparam int RL = 3;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    guess_solver_if #(.WIDTH(W), .ATT_W(AW)) bus();

    guess_solver #(.WIDTH(W), .RESP_LAT(RL), .ATT_W(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Responder: 0 truthful, 1 lies "over" at guess 0, 2 no flags, 3 over+equal
    int actual = 0;
    int mode   = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.i_over  <= 1'b0;
            bus.i_under <= 1'b0;
            bus.i_equal <= 1'b0;
        end else if (bus.o_enter) begin
            case (mode)
                2: begin
                    bus.i_over <= 1'b0; bus.i_under <= 1'b0; bus.i_equal <= 1'b0;
                end
                3: begin
                    bus.i_over <= 1'b1; bus.i_under <= 1'b0; bus.i_equal <= 1'b1;
                end
                default: begin
                    if (mode == 1 && bus.o_guess == 0) begin
                        bus.i_over <= 1'b1; bus.i_under <= 1'b0; bus.i_equal <= 1'b0;
                    end else begin
                        bus.i_over  <= (int'(bus.o_guess) > actual);
                        bus.i_under <= (int'(bus.o_guess) < actual);
                        bus.i_equal <= (int'(bus.o_guess) == actual);
                    end
                end
            endcase
        end
    end

    // Scoreboard monitor: each enter pulse pops the expected guess
    int exp_q[$];
    int cyc         = 0;
    int last_enter  = 0;
    int run_len     = 0;
    int enter_count = 0;
    bit first_enter = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.o_enter) begin
            run_len++;
            enter_count++;
            if (exp_q.size() > 0) check("guess", int'(bus.o_guess), exp_q.pop_front());
            if (!first_enter) check("enter_gap", cyc - last_enter, RL + 3);
            first_enter = 1'b0;
            last_enter  = cyc;
        end else if (run_len != 0) begin
            check("enter_width", run_len, 1);
            run_len = 0;
        end
    end

    // Independent model of the search: fills the queue, returns attempt count
    function automatic int build(input int a, input int m);
        int lo = 0;
        int hi = (1 << W) - 1;
        int g;
        int n = 0;
        exp_q.delete();
        forever begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            n++;
            if (m >= 2 || g == a) break;
            if (g > a) hi = g - 1; else lo = g + 1;
        end
        return n;
    endfunction

    task automatic wait_end(input bit spam);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_error) begin
                bus.i_start = 1'b0;
                break;
            end
            bus.i_start = spam ? ~bus.i_start : 1'b0;
        end
        bus.i_start = 1'b0;
        check("finished", int'(bus.o_done | bus.o_error), 1);
    endtask

    task automatic run(input int a, input int m, input bit spam, input bit exp_err);
        int n;
        actual = a;
        mode   = m;
        n = build(a, m);
        @(negedge clk);
        first_enter = 1'b1;
        enter_count = 0;
        bus.i_start = 1'b1;
        wait_end(spam);
        check("done",     int'(bus.o_done),     exp_err ? 0 : 1);
        check("error",    int'(bus.o_error),    exp_err ? 1 : 0);
        check("busy",     int'(bus.o_busy),     0);
        check("attempts", int'(bus.o_attempts), n);
        if (!exp_err) check("solved", int'(bus.o_guess), a);
        repeat (20) @(negedge clk);
        check("enter_count", enter_count, n);
        check("queue_left",  exp_q.size(), 0);
        check("hold_state",  int'({bus.o_done, bus.o_error}), exp_err ? 1 : 2);
    endtask

    initial begin
        int n;
        bus.i_start = 1'b0;
        #1;
        check("rst_guess",    int'(bus.o_guess),    0);
        check("rst_enter",    int'(bus.o_enter),    0);
        check("rst_busy",     int'(bus.o_busy),     0);
        check("rst_done",     int'(bus.o_done),     0);
        check("rst_error",    int'(bus.o_error),    0);
        check("rst_attempts", int'(bus.o_attempts), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(100, 0, 1'b0, 1'b0);
        run(255, 0, 1'b0, 1'b0);
        run(0,   0, 1'b0, 1'b0);
        run(77,  0, 1'b1, 1'b0);
        run(0,   1, 1'b0, 1'b1);
        run(100, 2, 1'b0, 1'b1);
        run(100, 3, 1'b0, 1'b1);

        // Asynchronous reset during S_WAIT of attempt 3
        actual = 100;
        mode   = 0;
        n = build(100, 0);
        @(negedge clk);
        first_enter = 1'b1;
        enter_count = 0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 100 && enter_count < 3; i++) @(negedge clk);
        check("third_press", enter_count, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_guess",    int'(bus.o_guess),    0);
        check("arst_enter",    int'(bus.o_enter),    0);
        check("arst_busy",     int'(bus.o_busy),     0);
        check("arst_attempts", int'(bus.o_attempts), 0);
        check("arst_flags",    int'({bus.o_done, bus.o_error}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Restart after reset: first guess 127, one attempt after the first press
        n = build(100, 0);
        @(negedge clk);
        first_enter = 1'b1;
        enter_count = 0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 100 && enter_count < 1; i++) @(negedge clk);
        @(negedge clk);
        check("first_attempt", int'(bus.o_attempts), 1);
        wait_end(1'b0);
        check("restart_done",     int'(bus.o_done),     1);
        check("restart_attempts", int'(bus.o_attempts), n);
        check("restart_solved",   int'(bus.o_guess),    100);

        // Start from S_DONE launches a fresh search
        run(200, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
